// File: rtl/mealy_pkg.sv
// Shared Mealy step definitions: state codes and the pure (cur, a) -> {next, z} step.
// Reused by the context scheduler and by any standalone detector.
package mealy_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef struct packed {
        logic [1:0] next;
        logic       z;
    } step_t;

    function automatic step_t mealy_step(input logic [1:0] cur, input logic a);
        step_t r;
        r.next = S0;
        r.z    = 1'b0;
        case (cur)
            S0: begin
                r.next = a ? S1 : S0;
                r.z    = a;
            end
            S1:      r.next = a ? S2 : S3;
            S2:      r.next = a ? S3 : S0;
            default: r.next = a ? S0 : S1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mealy_ctx_scheduler_if.sv
// Channel-side bundle of the context scheduler: requests, bits and clears in; grants and results out.
interface mealy_ctx_scheduler_if #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
);

    logic [N-1:0]    req;
    logic [N-1:0]    bit_a;
    logic [N-1:0]    clr;
    logic            hold;
    logic [N-1:0]    gnt;
    logic            z_valid;
    logic            z;
    logic [CH_W-1:0] z_ch;
    logic [1:0]      z_state;
    logic [2*N-1:0]  ctx_state;

    modport master (
        output req, bit_a, clr, hold,
        input  gnt, z_valid, z, z_ch, z_state, ctx_state
    );

    modport slave (
        input  req, bit_a, clr, hold,
        output gnt, z_valid, z, z_ch, z_state, ctx_state
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping at N-1.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic            hold,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [CH_W-1:0] idx
);

    always_comb begin
        int  cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && !hold && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = CH_W'(cand);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mealy_ctx_scheduler.sv
// Time-shares one Mealy step engine across N bit-serial channels, each with its own saved state.
// One granted bit per cycle; its result appears on z_* the following cycle.
module mealy_ctx_scheduler #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    mealy_ctx_scheduler_if.slave bus
);

    import mealy_pkg::*;

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W-1:0] next_ptr;
    logic [N-1:0]    gnt;
    logic [1:0]      ctx [N];
    logic [1:0]      cur;
    logic            transfer;
    step_t           step;

    logic            z_valid_q;
    logic            z_q;
    logic [CH_W-1:0] z_ch_q;
    logic [1:0]      z_state_q;

    // Reset is folded into hold so no grant is visible while rst is high.
    rr_arbiter #(.N(N), .CH_W(CH_W)) u_arb (
        .req  (bus.req),
        .hold (bus.hold | rst),
        .ptr  (rr_ptr),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    assign bus.gnt  = gnt;
    assign transfer = |gnt;

    // A clear on the granted channel applies before its bit is consumed.
    assign cur      = bus.clr[gnt_idx] ? S0 : ctx[gnt_idx];
    assign step     = mealy_step(cur, bus.bit_a[gnt_idx]);
    assign next_ptr = (gnt_idx == CH_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        bus.ctx_state = '0;
        for (int i = 0; i < N; i++) begin
            bus.ctx_state[2*i +: 2] = ctx[i];
        end
    end

    assign bus.z_valid = z_valid_q;
    assign bus.z       = z_q;
    assign bus.z_ch    = z_ch_q;
    assign bus.z_state = z_state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ctx[i] <= S0;
            end
            rr_ptr    <= '0;
            z_valid_q <= 1'b0;
            z_q       <= 1'b0;
            z_ch_q    <= '0;
            z_state_q <= S0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (transfer && gnt_idx == CH_W'(i)) begin
                    ctx[i] <= step.next;
                end else if (bus.clr[i]) begin
                    ctx[i] <= S0;
                end
            end
            if (transfer) begin
                rr_ptr    <= next_ptr;
                z_valid_q <= 1'b1;
                z_q       <= step.z;
                z_ch_q    <= gnt_idx;
                z_state_q <= step.next;
            end else begin
                z_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mealy_ctx_scheduler.sv
// Directed self-checking bench for mealy_ctx_scheduler (N=4) with hand-computed expectations.
module tb_mealy_ctx_scheduler;

    localparam int N    = 4;
    localparam int CH_W = 2;

    // Round-robin run with req=1111: bit_a=0110 for the first round, 1111 for the second.
    localparam logic [3:0] EXP_GNT [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    localparam logic       EXP_Z   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [1:0] EXP_ST  [8] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1};

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mealy_ctx_scheduler_if #(.N(N), .CH_W(CH_W)) bus ();

    mealy_ctx_scheduler #(.N(N), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] a,
                                 input logic [N-1:0] c, input logic h);
        bus.req   = r;
        bus.bit_a = a;
        bus.clr   = c;
        bus.hold  = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [CH_W-1:0] ch,
                               input logic zz, input logic [1:0] st);
        checkOutput({tag, "_zvalid"}, 32'(bus.z_valid), 32'd1);
        checkOutput({tag, "_z"},      32'(bus.z),       32'(zz));
        checkOutput({tag, "_zch"},    32'(bus.z_ch),    32'(ch));
        checkOutput({tag, "_zstate"}, 32'(bus.z_state), 32'(st));
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] start");

        // Reset state, with requests present to show gnt stays low during rst.
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 1'b0);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
        tick();
        tick();
        checkOutput("rst_zvalid", 32'(bus.z_valid), 32'h0);
        checkOutput("rst_z", 32'(bus.z), 32'h0);
        checkOutput("rst_zch", 32'(bus.z_ch), 32'h0);
        checkOutput("rst_zstate", 32'(bus.z_state), 32'h0);
        checkOutput("rst_ctx", 32'(bus.ctx_state), 32'h0);
        rst = 1'b0;

        // Channel 0 alone, bits 1,1,1,1.
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0);
        checkOutput("solo_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        checkResult("solo0", 2'd0, 1'b1, 2'd1);
        checkOutput("solo_gnt1", 32'(bus.gnt), 32'h1);
        tick();
        checkResult("solo1", 2'd0, 1'b0, 2'd2);
        tick();
        checkResult("solo2", 2'd0, 1'b0, 2'd3);
        tick();
        checkResult("solo3", 2'd0, 1'b0, 2'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("solo_idle_zvalid", 32'(bus.z_valid), 32'h0);
        checkOutput("solo_idle_zstate_hold", 32'(bus.z_state), 32'h0);
        checkOutput("solo_idle_ctx", 32'(bus.ctx_state), 32'h0);

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
        resetDut();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, (i < 4) ? 4'b0110 : 4'b1111, 4'b0000, 1'b0);
            checkOutput($sformatf("rr_gnt%0d", i), 32'(bus.gnt), 32'(EXP_GNT[i]));
            tick();
            checkResult($sformatf("rr%0d", i), CH_W'(i % 4), EXP_Z[i], EXP_ST[i]);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        checkOutput("rr_ctx", 32'(bus.ctx_state), 32'h69);

        // Clear channel 2 (S2) alone, then step it 1,1,1 to S3, then clear again.
        applyStimulus(4'b0000, 4'b0000, 4'b0100, 1'b0);
        tick();
        checkOutput("clr2_ctx", 32'(bus.ctx_state), 32'h49);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
            checkOutput($sformatf("ch2_gnt%0d", i), 32'(bus.gnt), 32'h4);
            tick();
        end
        checkResult("ch2_s3", 2'd2, 1'b0, 2'd3);
        checkOutput("ch2_s3_ctx", 32'(bus.ctx_state), 32'h79);
        applyStimulus(4'b0000, 4'b0000, 4'b0100, 1'b0);
        tick();
        checkOutput("clr2b_ctx", 32'(bus.ctx_state), 32'h49);
        checkOutput("clr2b_zvalid", 32'(bus.z_valid), 32'h0);

        // Channel 2 to S1, then clear+bit on ch2 together with an independent clear on ch0.
        applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0);
        tick();
        checkOutput("ch2_s1_ctx", 32'(bus.ctx_state), 32'h59);
        applyStimulus(4'b0100, 4'b0100, 4'b0101, 1'b0);
        checkOutput("clrstep_gnt", 32'(bus.gnt), 32'h4);
        tick();
        checkResult("clrstep", 2'd2, 1'b1, 2'd1);
        checkOutput("clrstep_ctx", 32'(bus.ctx_state), 32'h58);

        // Hold suppresses grants; release serves channel 1 then 3.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1010, 4'b1010, 4'b0000, 1'b1);
            checkOutput($sformatf("hold_gnt%0d", i), 32'(bus.gnt), 32'h0);
            tick();
            checkOutput($sformatf("hold_zvalid%0d", i), 32'(bus.z_valid), 32'h0);
        end
        applyStimulus(4'b1010, 4'b1010, 4'b0000, 1'b0);
        checkOutput("release_gnt_a", 32'(bus.gnt), 32'h2);
        tick();
        checkResult("release_a", 2'd1, 1'b1, 2'd1);
        checkOutput("release_gnt_b", 32'(bus.gnt), 32'h8);
        tick();
        checkResult("release_b", 2'd3, 1'b1, 2'd1);

        // All-zero streams keep every channel at S0; then channel 1 bits 0,1,0.
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b0000, 1'b0);
            tick();
            checkResult($sformatf("zero%0d", i), CH_W'(i), 1'b0, 2'd0);
        end
        checkOutput("zero_ctx", 32'(bus.ctx_state), 32'h0);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkResult("ch1_b0", 2'd1, 1'b0, 2'd0);
        applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0);
        tick();
        checkResult("ch1_b1", 2'd1, 1'b1, 2'd1);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkResult("ch1_b2", 2'd1, 1'b0, 2'd3);
        checkOutput("ch1_ctx", 32'(bus.ctx_state), 32'h0C);

        // Reset right after a transfer on channel 3 discards its result.
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0);
        checkOutput("pre_rst_gnt", 32'(bus.gnt), 32'h8);
        tick();
        rst = 1'b1;
        applyStimulus(4'b1001, 4'b0000, 4'b0000, 1'b0);
        checkOutput("midrst_gnt", 32'(bus.gnt), 32'h0);
        tick();
        checkOutput("midrst_zvalid", 32'(bus.z_valid), 32'h0);
        checkOutput("midrst_ctx", 32'(bus.ctx_state), 32'h0);
        checkOutput("midrst_zstate", 32'(bus.z_state), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("postrst_gnt", 32'(bus.gnt), 32'h1);
        tick();
        checkResult("postrst", 2'd0, 1'b0, 2'd0);

        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealy_ctx_scheduler.md
# mealy_ctx_scheduler

Round-robin scheduler that shares one 4-state Mealy step engine among N independent bit-serial channels. Each channel has its own 2-bit saved state. Each cycle the scheduler grants at most one requesting channel, advances that channel's state with the granted input bit, and emits the Mealy output tagged with the channel index. It sits between N serial bit sources and the downstream pattern-flag consumer, replacing N dedicated detector instances.

## Interface
Parameters:
- N, 4, number of channels (2..16)
- CH_W, $clog2(N), channel index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N  per-channel request; channel holds req and bit_a stable until granted
- bit_a  in  N  per-channel input bit A, valid when req[i]=1
- clr  in  N  per-channel context clear to state0
- hold  in  1  suppresses all grants while high
- gnt  out  N  one-hot grant, combinational from req, hold, rr_ptr
- z_valid  out  1  registered; pulses one cycle per consumed bit
- z  out  1  registered Mealy output for the consumed bit
- z_ch  out  CH_W  registered index of the channel the result belongs to
- z_state  out  2  registered next state written for z_ch
- ctx_state  out  2*N  saved state of channel i on bits [2i+1:2i], registered

## Operation
- State encoding: S0=00, S1=01, S2=10, S3=11.
- Step function (cur, A) -> (next, Z):
  - S0: A ? S1 : S0, with Z=A
  - S1: A ? S2 : S3, with Z=0
  - S2: A ? S3 : S0, with Z=0
  - S3: A ? S0 : S1, with Z=0
- Arbitration: search req from rr_ptr upward, wrapping at N-1 -> 0. The first set bit wins. No grant if hold=1 or req=0.
- Transfer: occurs on a cycle where req[i] & gnt[i]. On that edge:
  - ctx[i] <= next
  - rr_ptr <= (i+1) mod N
  - z_valid <= 1; z/z_ch/z_state are loaded.
- No transfer: z_valid <= 0. z, z_ch and z_state hold their last values. rr_ptr is unchanged.
- clr[i] without a transfer: ctx[i] <= S0 at the edge.
- clr[i] with a transfer on i in the same cycle: the step uses cur=S0, and ctx[i] <= next(S0, bit_a[i]). Clear is applied first, then the bit is consumed.
- clr on other channels is independent of the granted channel.
- Reset: all ctx=S0, rr_ptr=0, z_valid=0, z=0, z_ch=0, z_state=S0. gnt evaluates to 0 while rst=1. rst overrides clr and transfers.

## Timing
- gnt has zero latency from req; a source samples gnt in the same cycle.
- Result latency: one cycle. The result appears on z_* the cycle after the transfer.
- Throughput: one bit per cycle aggregate. With K channels requesting continuously, each is served once every K cycles.
- Back-to-back grants to the same channel are allowed only if it is the sole requester. The updated ctx is used on the next step with no hazard.
- hold asserted mid-stream: no grants from that cycle onward, and contexts are preserved. Service resumes at rr_ptr.
- rst mid-stream: any in-flight result is discarded, so z_valid=0 the cycle after.

## Structure
- Shared package mealy_pkg holds the state localparams S0..S3 and a pure function mealy_step(cur, a) returning {next, z}. The same package is reused by any standalone detector.
- One sub-module, rr_arbiter #(N): req, hold, ptr -> one-hot gnt plus encoded index. It is purely combinational. rr_ptr and the contexts live in mealy_ctx_scheduler.

## Test plan
- Reset, then req=4'b0001 with bit_a[0] sequence 1,1,1,1 -> z=1,0,0,0; z_state=S1,S2,S3,S0; z_ch=0 each time; z_valid 1 cycle after each gnt.
- req=4'b1111 held for 8 cycles after reset -> gnt order 0,1,2,3,0,1,2,3. Each channel advances exactly twice and contexts are interleaved correctly.
- Channel 2 stepped to S3 (bits 1,1,1), then clr[2] pulsed with no request -> ctx_state[5:4]=S0 next cycle. Channel 2 with clr[2]=1 and bit_a[2]=1 in the same cycle -> z=1, z_state=S1.
- hold=1 with req=4'b1010 for 3 cycles -> gnt=0 and z_valid=0. On hold release, channel 1 is granted first (rr_ptr=0), then channel 3.
- All channels at S0, bit_a=0 streams -> z=0 throughout and the state stays S0. Channel 1 bits 0,1,0 -> states S0,S1,S3 with z=0,1,0.
- rst asserted the cycle after a transfer on channel 3 -> z_valid=0, all ctx_state=0, and the next grant with req=4'b1001 goes to channel 0.
